// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state type, matrix sizes and the column decode helper
// used by the keypad scan controller.
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    typedef struct packed {
        logic       single;
        logic [1:0] idx;
    } col_info_t;

    // Columns are active-low; "single" is set only when exactly one column is pulled low.
    function automatic col_info_t col_onehot_to_idx(input logic [COLS-1:0] col_n);
        col_info_t       info;
        logic [COLS-1:0] low;
        low         = ~col_n;
        info.single = ($countones(low) == 1);
        info.idx    = 2'd0;
        for (int c = 0; c < COLS; c++) begin
            if (low[c]) begin
                info.idx = 2'(c);
            end
        end
        return info;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_tick_gen.sv
// scan_tick_gen: free-running divider that raises tick for one clk cycle
// every SCAN_DIV cycles, marking the end of a row dwell.
module scan_tick_gen #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    import keypad_pkg::*;

    localparam int                CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    assign tick = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with press/release debounce.
// Defining KEYPAD_REPEAT_EN adds auto-repeat of key_valid while a key is held.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4,
    parameter int REPEAT_DELAY = 250,
    parameter int REPEAT_RATE  = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);
    import keypad_pkg::*;

    localparam int               DEB_W    = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT);

    if (SCAN_DIV < 2 || DEBOUNCE_CNT < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("keypad_scan_ctrl: illegal parameter value");
    end

    state_t           state_q, state_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [KEY_W-1:0] key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_down_q, key_down_d;
    logic [ROWS-1:0]  row_out_q, row_out_d;
    logic             tick;
    col_info_t        col_info;
    logic             col_match;
    logic             lat_col_high;

`ifdef KEYPAD_REPEAT_EN
    localparam int               REP_W     = $clog2(((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE) + 1);
    localparam logic [REP_W-1:0] REP_DELAY = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_RATE  = REP_W'(REPEAT_RATE);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_armed_q, rep_armed_d;
`endif

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign col_info     = col_onehot_to_idx(col_in);
    assign col_match    = (col_in == ~(4'b0001 << col_idx_q));
    assign lat_col_high = col_in[col_idx_q];

    // The row index only moves on SCAN ticks and on leaving DEBOUNCE/RELEASE,
    // so the driven row stays frozen while a key is being tracked.
    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        deb_cnt_d   = deb_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
`endif
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (col_info.single) begin
                        col_idx_d = col_info.idx;
                        deb_cnt_d = DEB_W'(1);
                        state_d   = DEBOUNCE;
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!col_match) begin
                        state_d   = SCAN;
                        deb_cnt_d = '0;
                        row_idx_d = row_idx_q + 2'd1;
                    end else if (deb_cnt_q + DEB_W'(1) == DEB_LAST) begin
                        state_d     = PRESSED;
                        deb_cnt_d   = '0;
                        key_code_d  = {row_idx_q, col_idx_q};
                        key_valid_d = 1'b1;
                        key_down_d  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        rep_cnt_d   = '0;
                        rep_armed_d = 1'b0;
`endif
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_W'(1);
                    end
                end
                PRESSED: begin
                    if (lat_col_high) begin
                        state_d   = RELEASE;
                        deb_cnt_d = DEB_W'(1);
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        // First repeat after REPEAT_DELAY held ticks, then every REPEAT_RATE.
                        if (rep_cnt_q + REP_W'(1) == (rep_armed_q ? REP_RATE : REP_DELAY)) begin
                            key_valid_d = 1'b1;
                            rep_cnt_d   = '0;
                            rep_armed_d = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + REP_W'(1);
                        end
`endif
                    end
                end
                RELEASE: begin
                    if (!lat_col_high) begin
                        state_d   = PRESSED;
                        deb_cnt_d = '0;
                    end else if (deb_cnt_q + DEB_W'(1) == DEB_LAST) begin
                        state_d    = SCAN;
                        deb_cnt_d  = '0;
                        key_down_d = 1'b0;
                        row_idx_d  = row_idx_q + 2'd1;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DEB_W'(1);
                    end
                end
                default: begin
                    state_d = SCAN;
                end
            endcase
        end
        row_out_d = ~(4'b0001 << row_idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            deb_cnt_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            row_out_q   <= 4'b1110;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            deb_cnt_q   <= deb_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
            row_out_q   <= row_out_d;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
`endif
        end
    end

    assign row_out   = row_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: keypad matrix model plus scoreboard of expected key_valid
// pulses for keypad_scan_ctrl (SCAN_DIV=4, DEBOUNCE_CNT=3).
module tb_keypad_scan_ctrl;

    localparam int SD = 4;
    localparam int DC = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    typedef struct {
        logic [3:0] code;
        int         cyc;
        logic [3:0] row;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] pressed;
    int          cyc;
    int          tests_run;
    int          tests_failed;
    exp_t        exp_q[$];

    keypad_scan_ctrl #(
        .SCAN_DIV     (SD),
        .DEBOUNCE_CNT (DC),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Passive matrix: a held key pulls its column low only while its row is driven low.
    always_comb begin
        col_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !row_out[r]) begin
                    col_in[c] = 1'b0;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic wait_row_change(input int r, output int t0);
        logic [3:0] target;
        logic [3:0] prev;
        bit         found;
        target = ~(4'b0001 << r);
        found  = 1'b0;
        t0     = 0;
        @(negedge clk);
        prev = row_out;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (row_out == target && prev != target) begin
                found = 1'b1;
                t0    = cyc;
            end
            prev = row_out;
        end
        if (!found) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL row_wait: row_out %b never switched to %b", row_out, target);
        end
    endtask

    // Press the keys in cols of row r from the start of that row's dwell for h samples.
    task automatic apply_stimulus(input int r, input logic [3:0] cols, input int h);
        int         t0;
        int         ncol;
        int         cidx;
        exp_t       e;
        logic [3:0] rp;
        ncol = 0;
        cidx = 0;
        rp   = ~(4'b0001 << r);
        for (int c = 0; c < 4; c++) begin
            if (cols[c]) begin
                ncol++;
                cidx = c;
            end
        end
        wait_row_change(r, t0);
        for (int c = 0; c < 4; c++) begin
            if (cols[c]) pressed[r*4+c] = 1'b1;
        end
        if (ncol == 1 && h >= DC) begin
            e.code = 4'(r*4 + cidx);
            e.cyc  = t0 + SD*DC;
            e.row  = rp;
            exp_q.push_back(e);
`ifdef KEYPAD_REPEAT_EN
            for (int s = DC + RD; s <= h; s += RR) begin
                e.cyc = t0 + SD*s;
                exp_q.push_back(e);
            end
`endif
        end
        repeat (h*SD) @(negedge clk);
        pressed = '0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_valid: got key_code %0h at cycle %0d, expected no pulse", key_code, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_output("valid_code", 32'(key_code), 32'(e.code));
                    check_output("valid_cycle", 32'(cyc), 32'(e.cyc));
                    check_output("valid_key_down", 32'(key_down), 32'd1);
                    check_output("valid_row_frozen", 32'(row_out), 32'(e.row));
                end
            end
        end
    end

    initial begin
        #2000000;
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t0;
        tests_run    = 0;
        tests_failed = 0;
        pressed      = '0;
        rst          = 1'b1;

        repeat (2) @(negedge clk);
        check_output("rst_row_out", 32'(row_out), 32'h0000000e);
        check_output("rst_key_code", 32'(key_code), 32'd0);
        check_output("rst_key_valid", 32'(key_valid), 32'd0);
        check_output("rst_key_down", 32'(key_down), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_output("dwell_row0_hold", 32'(row_out), 32'h0000000e);
        @(negedge clk);
        check_output("dwell_row1", 32'(row_out), 32'h0000000d);
        repeat (8) @(negedge clk);
        check_output("dwell_row3", 32'(row_out), 32'h00000007);
        repeat (4) @(negedge clk);
        check_output("dwell_wrap_row0", 32'(row_out), 32'h0000000e);

        // Clean press of row2/col1 -> code 9
        apply_stimulus(2, 4'b0010, 4);
        repeat ((DC+2)*SD) @(negedge clk);
        check_output("clean_drained", 32'(exp_q.size()), 32'd0);

        // One-sample bounce on row2: no pulse, scanning resumes at row3
        wait_row_change(2, t0);
        pressed[9] = 1'b1;
        repeat (SD) @(negedge clk);
        pressed = '0;
        repeat (SD-1) @(negedge clk);
        check_output("bounce_row_frozen", 32'(row_out), 32'h0000000b);
        @(negedge clk);
        check_output("bounce_row_resume", 32'(row_out), 32'h00000007);
        check_output("bounce_code_kept", 32'(key_code), 32'h00000009);
        check_output("bounce_key_down", 32'(key_down), 32'd0);

        // Row0/col3 press, one-sample release glitch, then a full release
        wait_row_change(0, t0);
        pressed[3] = 1'b1;
        begin
            exp_t e;
            e.code = 4'h3;
            e.cyc  = t0 + SD*DC;
            e.row  = 4'b1110;
            exp_q.push_back(e);
        end
        repeat (5*SD) @(negedge clk);
        pressed[3] = 1'b0;
        repeat (SD) @(negedge clk);
        pressed[3] = 1'b1;
        repeat (SD) @(negedge clk);
        check_output("glitch_key_down", 32'(key_down), 32'd1);
        check_output("glitch_row_frozen", 32'(row_out), 32'h0000000e);
        repeat (SD) @(negedge clk);
        pressed[3] = 1'b0;
        repeat (2*SD) @(negedge clk);
        check_output("release_pending_down", 32'(key_down), 32'd1);
        check_output("release_pending_row", 32'(row_out), 32'h0000000e);
        repeat (SD) @(negedge clk);
        check_output("release_key_down", 32'(key_down), 32'd0);
        check_output("release_row_adv", 32'(row_out), 32'h0000000d);
        check_output("release_code", 32'(key_code), 32'h00000003);

        // Two columns low on row1 is ignored
        wait_row_change(1, t0);
        pressed[4] = 1'b1;
        pressed[6] = 1'b1;
        repeat (SD) @(negedge clk);
        check_output("multi_row_adv", 32'(row_out), 32'h0000000b);
        check_output("multi_key_down", 32'(key_down), 32'd0);
        repeat (3*SD) @(negedge clk);
        pressed = '0;

        // Reset while PRESSED on row3/col2
        wait_row_change(3, t0);
        pressed[14] = 1'b1;
        begin
            exp_t e;
            e.code = 4'he;
            e.cyc  = t0 + SD*DC;
            e.row  = 4'b0111;
            exp_q.push_back(e);
        end
        repeat (4*SD) @(negedge clk);
        check_output("pre_rst_key_down", 32'(key_down), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_output("midrst_key_down", 32'(key_down), 32'd0);
        check_output("midrst_key_code", 32'(key_code), 32'd0);
        check_output("midrst_row_out", 32'(row_out), 32'h0000000e);
        check_output("midrst_key_valid", 32'(key_valid), 32'd0);
        pressed = '0;
        rst = 1'b0;
        repeat (2*SD) @(negedge clk);
        check_output("midrst_drained", 32'(exp_q.size()), 32'd0);

`ifdef KEYPAD_REPEAT_EN
        apply_stimulus(1, 4'b0100, 12);
        repeat ((DC+2)*SD) @(negedge clk);
        check_output("repeat_drained", 32'(exp_q.size()), 32'd0);
`endif

        // Random presses, bounces and multi-key patterns
        for (int i = 0; i < 30; i++) begin
            int         r;
            int         c;
            int         c2;
            int         mode;
            int         h;
            logic [3:0] cols;
            r    = int'($urandom_range(0, 3));
            c    = int'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 2));
            cols = 4'b0001 << c;
            if (mode == 0) begin
                h = int'($urandom_range(DC, DC+2));
            end else if (mode == 1) begin
                h = int'($urandom_range(1, DC-1));
            end else begin
                c2   = (c + 1 + int'($urandom_range(0, 2))) % 4;
                cols = cols | (4'b0001 << c2);
                h    = int'($urandom_range(1, 5));
            end
            apply_stimulus(r, cols, h);
            repeat ((DC+2)*SD) @(negedge clk);
            check_output("rand_drained", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
